fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end that feeds the IF/ID register of the 5-stage MIPS pipeline. It owns the program counter and issues in-order requests to a handshaked instruction memory. Returned instructions are buffered in a small prefetch queue, and each one is presented with its PC+4 value. It also handles branch redirects from the MEM stage and holds its output while the decode stage stalls.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_prefetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word width, NOP encoding, default reset PC and fetch entry layout.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with push, pop, flush and occupancy reporting.
// Push and pop in the same cycle are legal at any occupancy, including full.
module fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests, prefetch queue, branch redirect.
// Optional same-cycle response bypass to the decode outputs is enabled by defining FETCH_BYPASS_EN.
module fetch_prefetch_unit
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction_IF,
  output logic [31:0] PC_sumado_IF,
  output logic        instr_valid_IF
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             req_acc, drop_rsp, bypass_hit, enq, deq;
  logic [CNT_W:0]   inflight;
  fetch_entry_t     entry_wr, entry_head;
  logic [CNT_W-1:0] entry_cnt, tag_cnt;
  logic             entry_full, entry_empty, tag_full, tag_empty;
  logic [31:0]      tag_head;
  logic             unused_sigs;

  assign inflight       = {1'b0, outstanding_q} + {1'b0, entry_cnt};
  assign imem_req_valid = ~rst & (inflight < (CNT_W + 1)'(DEPTH)) & ~tag_full;
  assign imem_req_addr  = fetch_pc_q;
  assign req_acc        = imem_req_valid & imem_req_ready;

  assign drop_rsp = redirect_valid | (discard_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = entry_empty & (discard_q == '0) & imem_rsp_valid & ~redirect_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed response consumed this cycle never touches the queue.
  assign enq = imem_rsp_valid & ~drop_rsp & ~(bypass_hit & ~stall);
  assign deq = ~entry_empty & ~stall;

  assign entry_wr.instr    = imem_rsp_data;
  assign entry_wr.pc_plus4 = tag_head + 32'd4;

  fetch_fifo #(.DATA_W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
    .clk    (clk),
    .rst    (rst),
    .push_i (enq),
    .pop_i  (deq),
    .flush_i(redirect_valid),
    .din_i  (entry_wr),
    .dout_o (entry_head),
    .count_o(entry_cnt),
    .full_o (entry_full),
    .empty_o(entry_empty)
  );

  // Tags are popped by every response, dropped or not, so they stay aligned across redirects.
  fetch_fifo #(.DATA_W(32), .DEPTH(DEPTH)) u_tag_q (
    .clk    (clk),
    .rst    (rst),
    .push_i (req_acc),
    .pop_i  (imem_rsp_valid & ~tag_empty),
    .flush_i(1'b0),
    .din_i  (fetch_pc_q),
    .dout_o (tag_head),
    .count_o(tag_cnt),
    .full_o (tag_full),
    .empty_o(tag_empty)
  );

  assign unused_sigs = ^{entry_full, tag_cnt};

  always_comb begin
    instruction_IF = NOP_INSTR;
    PC_sumado_IF   = '0;
    instr_valid_IF = 1'b0;
    if (bypass_hit) begin
      instruction_IF = imem_rsp_data;
      PC_sumado_IF   = tag_head + 32'd4;
      instr_valid_IF = 1'b1;
    end else if (!entry_empty) begin
      instruction_IF = entry_head.instr;
      PC_sumado_IF   = entry_head.pc_plus4;
      instr_valid_IF = 1'b1;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_acc, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    discard_d = discard_q;
    if (redirect_valid)                          discard_d = outstanding_d;
    else if (imem_rsp_valid && discard_q != '0)  discard_d = discard_q - 1'b1;

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (req_acc)   fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model plus a queue-level reference of the fetch front end.
module tb_fetch_prefetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instruction_IF;
  logic [31:0] PC_sumado_IF;
  logic        instr_valid_IF;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instruction_IF(instruction_IF),
    .PC_sumado_IF  (PC_sumado_IF),
    .instr_valid_IF(instr_valid_IF)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory contents and in-flight requests.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1, rsp_pct = 100;

  // Reference: queued entries (by request PC), pending discards, next request PC, next program PC.
  logic [31:0] mq[$];
  int          md = 0;
  logic [31:0] req_pc = RST_PC;
  logic [31:0] exp_prog = RST_PC;

  // Outputs seen in the most recent cycle.
  logic        r_valid, r_req_valid;
  logic [31:0] r_instr, r_pc, r_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic step(input bit st, input bit rdv, input logic [31:0] rdpc,
                      input bit rdy, input bit rs);
    bit          rv, byp, exp_rq, acc, exp_v;
    logic [31:0] exp_i, exp_p, a;
    int          lat;
    rst            = rs;
    stall          = st;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    imem_req_ready = rdy;
    rv = !rs && pend_addr.size() > 0 && pend_due[0] <= cyc &&
         (int'($urandom_range(99)) < rsp_pct);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? memf(pend_addr[0]) : $urandom;
    #1;
    r_valid = instr_valid_IF; r_instr = instruction_IF; r_pc = PC_sumado_IF;
    r_req_valid = imem_req_valid; r_addr = imem_req_addr;

    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = rv && mq.size() == 0 && md == 0 && !rdv;
`endif
    exp_rq = !rs && (pend_addr.size() + mq.size() < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rq});
    if (!rs) begin
      if (byp) begin
        exp_v = 1'b1; exp_i = memf(pend_addr[0]); exp_p = pend_addr[0] + 32'd4;
      end else if (mq.size() > 0) begin
        exp_v = 1'b1; exp_i = memf(mq[0]); exp_p = mq[0] + 32'd4;
      end else begin
        exp_v = 1'b0; exp_i = 32'h0; exp_p = 32'h0;
      end
      chk("instr_valid", {31'b0, instr_valid_IF}, {31'b0, exp_v});
      chk("instruction", instruction_IF, exp_i);
      chk("pc_plus4", PC_sumado_IF, exp_p);
      chk("req_addr", imem_req_addr, req_pc);
    end

    acc = exp_rq && rdy;
    lat = lat_min + int'($urandom_range(lat_max - lat_min));
    a   = 32'h0;
    if (rs) begin
      pend_addr.delete(); pend_due.delete(); mq.delete();
      md = 0; req_pc = RST_PC; exp_prog = RST_PC;
    end else begin
      if (rv) begin
        a = pend_addr.pop_front();
        void'(pend_due.pop_front());
      end
      if (rdv) begin
        mq.delete();
        if (acc) begin pend_addr.push_back(req_pc); pend_due.push_back(cyc + lat); end
        md = pend_addr.size();
        req_pc = rdpc;
        exp_prog = rdpc;
      end else begin
        if (mq.size() > 0 && !st) begin
          chk("program_order", mq[0], exp_prog);
          exp_prog += 32'd4;
          void'(mq.pop_front());
        end
        if (rv) begin
          if (md > 0) md--;
          else if (byp && !st) begin
            chk("program_order", a, exp_prog);
            exp_prog += 32'd4;
          end else mq.push_back(a);
        end
        if (acc) begin
          pend_addr.push_back(req_pc);
          pend_due.push_back(cyc + lat);
          req_pc += 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp_pc4);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (r_valid) found = 1'b1;
    end
    chk({nm, "_found"}, {31'b0, found}, 32'h1);
    if (found) chk(nm, r_pc, exp_pc4);
  endtask

  initial begin
    logic [31:0] rpc;
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("rst_req_valid", {31'b0, r_req_valid}, 32'h0);
    chk("rst_req_addr", r_addr, RST_PC);
    chk("rst_instr_valid", {31'b0, r_valid}, 32'h0);
    chk("rst_instr", r_instr, 32'h0);
    chk("rst_pc4", r_pc, 32'h0);

    // Free run, 1-cycle memory, addresses wrap through zero.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (k == 0) begin
        chk("first_req_valid", {31'b0, r_req_valid}, 32'h1);
        chk("addr0", r_addr, 32'hFFFF_FFF8);
      end
      if (k == 1) begin
        chk("addr1", r_addr, 32'hFFFF_FFFC);
`ifdef FETCH_BYPASS_EN
        chk("bypass_valid", {31'b0, r_valid}, 32'h1);
        chk("bypass_pc4", r_pc, 32'hFFFF_FFFC);
        chk("bypass_instr", r_instr, 32'h2152_FFF8);
`else
        chk("no_valid_yet", {31'b0, r_valid}, 32'h0);
`endif
      end
      if (k == 2) begin
        chk("addr2", r_addr, 32'h0000_0000);
        chk("third_valid", {31'b0, r_valid}, 32'h1);
`ifndef FETCH_BYPASS_EN
        chk("third_pc4", r_pc, 32'hFFFF_FFFC);
        chk("third_instr", r_instr, 32'h2152_FFF8);
`endif
      end
    end

    // Five-cycle stall: output holds, credits run out.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef FETCH_BYPASS_EN
      chk("stall_hold_pc4", r_pc, 32'h0000_0018);
`else
      chk("stall_hold_pc4", r_pc, 32'h0000_0014);
`endif
    end
    chk("stall_credit_stop", {31'b0, r_req_valid}, 32'h0);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Redirect with two-cycle memory (two requests in flight).
    lat_min = 2; lat_max = 2;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("redirect_addr", r_addr, 32'h0000_0100);
    wait_valid("redirect_first_pc4", 32'h0000_0104);

    // Redirect coinciding with a response and an accept.
    lat_min = 1; lat_max = 1;
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    wait_valid("redirect2_first_pc4", 32'h0000_0204);

    // Memory not ready for three cycles after a redirect.
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("ready_low_addr", r_addr, 32'h0000_0300);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("ready_back_addr", r_addr, 32'h0000_0300);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("ready_next_addr", r_addr, 32'h0000_0304);

    // Randomised traffic with a mid-run reset.
    lat_min = 1; lat_max = 4; rsp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      bit st, rdv, rdy, rs;
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0;
      st  = ($urandom_range(99) < 30);
      rdv = ($urandom_range(99) < 3);
      rdy = ($urandom_range(99) < 70);
      rs  = (i >= 1500 && i < 1502);
      step(st, rdv, rpc, rdy, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
